// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button front end: per-bit debounce FSM
// encoding and the board button index map.
package btn_conditioner_pkg;

  // Debounce FSM: two stable states and two counting states between them.
  typedef enum logic [1:0] {
    REL    = 2'd0,  // stable released
    CNT_UP = 2'd1,  // qualifying a press
    PRS    = 2'd2,  // stable pressed
    CNT_DN = 2'd3   // qualifying a release
  } btn_state_e;

  // Bit positions of the board buttons within btn_raw / btn_level / strobes.
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser, stability counter and FSM.
// Produces a registered debounced level plus one-cycle press/release strobes.
module btn_debounce
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  // Count value at which the current cycle completes the stable window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  btn_state_e       w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_level_next;
  logic             w_press_next;
  logic             w_release_next;

  // Bring the asynchronous pin into the clk domain; only r_sync2 is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic: a transition must survive a full window of stable
  // samples; any sample back at the old value aborts and clears the count.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_level_next   = r_level;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    case (r_state)
      REL: begin
        if (r_sync2) begin
          w_state_next = CNT_UP;
          w_cnt_next   = CNT_ONE;
        end
      end
      CNT_UP: begin
        if (!r_sync2) begin
          w_state_next = REL;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = PRS;
          w_cnt_next   = '0;
          w_level_next = 1'b1;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      PRS: begin
        if (!r_sync2) begin
          w_state_next = CNT_DN;
          w_cnt_next   = CNT_ONE;
        end
      end
      CNT_DN: begin
        if (r_sync2) begin
          w_state_next = PRS;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next   = REL;
          w_cnt_next     = '0;
          w_level_next   = 1'b0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = REL;
        w_cnt_next   = '0;
      end
    endcase
  end

  // FSM, counter and output registers; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= REL;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: one independent debounce channel per button.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Channels share nothing but clock and reset.
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw[gi]),
        .btn_level   (btn_level[gi]),
        .btn_press   (btn_press[gi]),
        .btn_release (btn_release[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing, all
// compared cycle by cycle against a run-length reference model.
module tb_btn_conditioner;

  localparam int NB = 5;
  localparam int DC = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: raw is seen by the decision logic two edges after it is
  // sampled; the debounced level flips once the delayed input has disagreed
  // with it for DC consecutive edges, and any agreement restarts the run.
  logic [NB-1:0] m_d1  = '0;
  logic [NB-1:0] m_d2  = '0;
  logic [NB-1:0] m_lvl = '0;
  logic [NB-1:0] m_prs = '0;
  logic [NB-1:0] m_rel = '0;
  int            m_run [NB];

  task automatic model_step(input logic [NB-1:0] raw, input logic r);
    if (r) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int b = 0; b < NB; b++) m_run[b] = 0;
    end else begin
      m_prs = '0;
      m_rel = '0;
      for (int b = 0; b < NB; b++) begin
        if (m_d2[b] != m_lvl[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DC) begin
            m_lvl[b] = m_d2[b];
            if (m_d2[b]) m_prs[b] = 1'b1;
            else         m_rel[b] = 1'b1;
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
  endtask

  // One clock: drive on the falling edge, step the model at the rising edge,
  // compare shortly after it.
  task automatic tick(input logic [NB-1:0] raw, input logic r);
    @(negedge clk);
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    model_step(raw, r);
    #1;
    chk("level",   {27'd0, btn_level},   {27'd0, m_lvl});
    chk("press",   {27'd0, btn_press},   {27'd0, m_prs});
    chk("release", {27'd0, btn_release}, {27'd0, m_rel});
    chk("overlap", {27'd0, btn_press & btn_release}, 32'd0);
  endtask

  initial begin
    int n;
    logic [NB-1:0] cur;
    for (int b = 0; b < NB; b++) m_run[b] = 0;
    btn_raw = '0;
    rst     = 1'b1;

    // Reset state
    tick(5'b00000, 1'b1);
    tick(5'b00000, 1'b1);
    chk("rst_level", {27'd0, btn_level}, 32'd0);
    chk("rst_strobes", {27'd0, btn_press | btn_release}, 32'd0);
    $display("reset done");

    // 1. Clean press on btnd, then release
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(5'b10000, 1'b0);
      if (btn_press[4]) begin
        n++;
        chk("s1_latency", i + 1, 6);
      end
    end
    chk("s1_press_count", n, 1);
    for (int i = 0; i < 10; i++) tick(5'b00000, 1'b0);
    $display("scenario 1 clean press done");

    // 2. Glitch on btnc shorter than the window
    n = 0;
    for (int i = 0; i < 13; i++) begin
      tick((i < 3) ? 5'b00001 : 5'b00000, 1'b0);
      if (btn_level[0] | btn_press[0] | btn_release[0]) n++;
    end
    chk("s2_glitch_activity", n, 0);
    $display("scenario 2 glitch done");

    // 3. Bounce on btnr, then held high
    n = 0;
    for (int i = 0; i < 8; i++) tick((i % 2 == 0) ? 5'b00100 : 5'b00000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(5'b00100, 1'b0);
      if (btn_press[2]) begin
        n++;
        chk("s3_latency", i + 1, 6);
      end
    end
    chk("s3_press_count", n, 1);
    for (int i = 0; i < 10; i++) tick(5'b00000, 1'b0);
    $display("scenario 3 bounce done");

    // 4. Release of btnl from a stable press
    for (int i = 0; i < 10; i++) tick(5'b00010, 1'b0);
    chk("s4_level_before", {31'd0, btn_level[1]}, 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(5'b00000, 1'b0);
      if (btn_release[1]) begin
        n++;
        chk("s4_latency", i + 1, 6);
      end
      chk("s4_no_press", {31'd0, btn_press[1]}, 32'd0);
    end
    chk("s4_release_count", n, 1);
    $display("scenario 4 release done");

    // 5. Simultaneous press on btnl and btnr
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(5'b00110, 1'b0);
      if (btn_press != '0) begin
        n++;
        chk("s5_press_vec", {27'd0, btn_press}, 32'h06);
      end
    end
    chk("s5_press_count", n, 1);
    for (int i = 0; i < 10; i++) tick(5'b00000, 1'b0);
    $display("scenario 5 simultaneous done");

    // 6. Reset while btnu is part way through its count
    for (int i = 0; i < 4; i++) tick(5'b01000, 1'b0);
    tick(5'b01000, 1'b1);
    chk("s6_after_rst", {27'd0, btn_level | btn_press | btn_release}, 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(5'b01000, 1'b0);
      if (btn_press[3]) begin
        n++;
        chk("s6_latency", i + 1, 6);
      end
    end
    chk("s6_press_count", n, 1);
    for (int i = 0; i < 10; i++) tick(5'b00000, 1'b0);
    $display("scenario 6 reset mid-count done");

    // Random bouncing on all bits with occasional reset
    cur = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      tick(cur, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
